// File: rtl/sign_extend_unit.sv
// Immediate widener: sign, zero, short-sign and word-scaled extension of IN_W to OUT_W bits.
// Optional registered status flags (is_neg, is_zero) are enabled by defining SIGN_EXTEND_STATUS_EN.
module sign_extend_unit #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
`ifdef SIGN_EXTEND_STATUS_EN
  output logic             is_neg,
  output logic             is_zero,
`endif
  output logic             out_valid
);

  logic [OUT_W-1:0] sx;

  assign sx = {{(OUT_W-IN_W){in[IN_W-1]}}, in};

  // mode 00 falls to default so an unknown mode still yields the sign-extended value
  always_comb begin
    out = sx;
    case (mode)
      2'b01:   out = {{(OUT_W-IN_W){1'b0}}, in};
      2'b10:   out = {{(OUT_W-6){in[5]}}, in[5:0]};
      2'b11:   out = {sx[OUT_W-2:0], 1'b0};
      default: out = sx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_q <= out;
    end
  end

`ifdef SIGN_EXTEND_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      is_neg  <= 1'b0;
      is_zero <= 1'b0;
    end else if (in_valid) begin
      is_neg  <= out[OUT_W-1];
      is_zero <= (out == '0);
    end
  end
`endif

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit: directed vectors plus randomized comb and pipeline checks.
// Define SIGN_EXTEND_STATUS_EN to also check is_neg/is_zero.
module tb_sign_extend_unit;

  localparam int IN_W  = 9;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in;
  logic [1:0]       mode;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic             out_valid;
`ifdef SIGN_EXTEND_STATUS_EN
  logic             is_neg;
  logic             is_zero;
`endif

  int checks = 0;
  int errors = 0;

  sign_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .mode(mode),
    .in_valid(in_valid),
    .out(out),
    .out_q(out_q),
`ifdef SIGN_EXTEND_STATUS_EN
    .is_neg(is_neg),
    .is_zero(is_zero),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: interpret the field as a signed integer, then reduce modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] ref_ext(input int unsigned raw, input int unsigned m);
    int v;
    int unsigned low6;
    low6 = raw % 64;
    case (m)
      1: v = int'(raw);
      2: v = (low6 >= 32) ? int'(low6) - 64 : int'(low6);
      3: v = ((raw >= (1 << (IN_W-1))) ? int'(raw) - (1 << IN_W) : int'(raw)) * 2;
      default: v = (raw >= (1 << (IN_W-1))) ? int'(raw) - (1 << IN_W) : int'(raw);
    endcase
    return v[OUT_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; mode = 2'b00; in = 9'h1FB;
    tick();
    tick();
    checks++;
    if (out_q !== 16'h0000) begin
      errors++; $display("FAIL reset_out_q actual=%h required=%h", out_q, 16'h0000);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid actual=%b required=%b", out_valid, 1'b0);
    end
`ifdef SIGN_EXTEND_STATUS_EN
    checks++;
    if (is_neg !== 1'b0 || is_zero !== 1'b0) begin
      errors++; $display("FAIL reset_status actual=%b%b required=00", is_neg, is_zero);
    end
`endif
    // comb path must be live while rst is held
    checks++;
    if (out !== 16'hFFFB) begin
      errors++; $display("FAIL comb_during_rst actual=%h required=%h", out, 16'hFFFB);
    end
  endtask

  task automatic test_directed();
    logic [IN_W-1:0]  vin  [12] = '{9'h005, 9'h1FB, 9'h000, 9'h0FF, 9'h100, 9'h1FF,
                                   9'h1FB, 9'h03B, 9'h1C5, 9'h1FB, 9'h0FF, 9'h100};
    logic [1:0]       vmd  [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                   2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [OUT_W-1:0] vexp [12] = '{16'h0005, 16'hFFFB, 16'h0000, 16'h00FF, 16'hFF00, 16'hFFFF,
                                   16'h01FB, 16'hFFFB, 16'h0005, 16'hFFF6, 16'h01FE, 16'hFE00};
    for (int i = 0; i < 12; i++) begin
      in = vin[i]; mode = vmd[i];
      #1;
      checks++;
      if (out !== vexp[i]) begin
        errors++;
        $display("FAIL directed[%0d] in=%h mode=%0d actual=%h required=%h", i, vin[i], vmd[i], out, vexp[i]);
      end
    end
  endtask

  task automatic test_random_comb();
    logic [OUT_W-1:0] e;
    for (int i = 0; i < 200; i++) begin
      in = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      mode = 2'($urandom_range(0, 3));
      #1;
      e = ref_ext(int'(in), int'(mode));
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL rand_comb in=%h mode=%0d actual=%h required=%h", in, mode, out, e);
      end
    end
  endtask

  task automatic test_registered();
    rst = 1'b0; in_valid = 1'b1; mode = 2'b00; in = 9'h1FB;
    tick();
    checks++;
    if (out_q !== 16'hFFFB || out_valid !== 1'b1) begin
      errors++; $display("FAIL reg_capture actual=%h/%b required=FFFB/1", out_q, out_valid);
    end
    in_valid = 1'b0; in = 9'h000;
    tick();
    checks++;
    if (out_q !== 16'hFFFB || out_valid !== 1'b0) begin
      errors++; $display("FAIL reg_hold actual=%h/%b required=FFFB/0", out_q, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [IN_W-1:0]  sin [3] = '{9'h005, 9'h100, 9'h0FF};
    logic [OUT_W-1:0] sex [3] = '{16'h0005, 16'hFF00, 16'h00FF};
    rst = 1'b0; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = sin[i];
      tick();
      checks++;
      if (out_q !== sex[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] actual=%h/%b required=%h/1", i, out_q, out_valid, sex[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    rst = 1'b0; in_valid = 1'b1; mode = 2'b00; in = 9'h1FB;
    tick();
    rst = 1'b1; in = 9'h0FF;
    tick();
    checks++;
    if (out_q !== 16'h0000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midstream_rst actual=%h/%b required=0000/0", out_q, out_valid);
    end
    rst = 1'b0;
  endtask

`ifdef SIGN_EXTEND_STATUS_EN
  task automatic test_status();
    rst = 1'b0; in_valid = 1'b1; mode = 2'b00; in = 9'h100;
    tick();
    checks++;
    if (is_neg !== 1'b1 || is_zero !== 1'b0) begin
      errors++; $display("FAIL status_neg actual=%b%b required=10", is_neg, is_zero);
    end
    in = 9'h000;
    tick();
    checks++;
    if (is_neg !== 1'b0 || is_zero !== 1'b1) begin
      errors++; $display("FAIL status_zero actual=%b%b required=01", is_neg, is_zero);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (is_neg !== 1'b0 || is_zero !== 1'b0) begin
      errors++; $display("FAIL status_rst actual=%b%b required=00", is_neg, is_zero);
    end
    rst = 1'b0;
  endtask
`endif

  task automatic test_random_pipeline();
    logic [OUT_W-1:0] eq = '0;
    logic             ev = 1'b0;
    logic [OUT_W-1:0] r;
`ifdef SIGN_EXTEND_STATUS_EN
    logic en = 1'b0, ez = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in       = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      mode     = 2'($urandom_range(0, 3));
      r = ref_ext(int'(in), int'(mode));
      if (rst) begin
        eq = '0; ev = 1'b0;
`ifdef SIGN_EXTEND_STATUS_EN
        en = 1'b0; ez = 1'b0;
`endif
      end else begin
        ev = in_valid;
        if (in_valid) begin
          eq = r;
`ifdef SIGN_EXTEND_STATUS_EN
          en = r[OUT_W-1]; ez = (r == 0);
`endif
        end
      end
      tick();
      checks++;
      if (out_q !== eq || out_valid !== ev) begin
        errors++; $display("FAIL rand_pipe[%0d] actual=%h/%b required=%h/%b", i, out_q, out_valid, eq, ev);
      end
`ifdef SIGN_EXTEND_STATUS_EN
      checks++;
      if (is_neg !== en || is_zero !== ez) begin
        errors++; $display("FAIL rand_status[%0d] actual=%b%b required=%b%b", i, is_neg, is_zero, en, ez);
      end
`endif
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; mode = 2'b00;
    #2;
    test_reset();
    test_directed();
    test_random_comb();
    test_registered();
    test_back_to_back();
    test_midstream_reset();
`ifdef SIGN_EXTEND_STATUS_EN
    test_status();
`endif
    test_random_pipeline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
